ms_slave_arbiter: RTL

- Round-robin arbiter sharing one master-slave slave port among NUM_MASTERS requesters.
- Each requester issues a blocking request word. The arbiter forwards the granted word to the slave with a one-cycle sync strobe, waits for the slave's synced response, and returns that response to the granted requester only.
- Sits between the requester masters and a single master-slave datapath block (s_in/s_in_sync style interface).

---
 rtl/ms_slave_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ms_slave_arbiter.sv
// Round-robin arbiter that shares one master-slave slave port among NUM_MASTERS requesters.
// Define MS_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES and return an error response.
module ms_slave_arbiter #(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int GW             = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        req_valid,
  input  logic [NUM_MASTERS*DATA_W-1:0] req_data,
  output logic [NUM_MASTERS-1:0]        req_ready,
  output logic [NUM_MASTERS-1:0]        resp_valid,
  output logic [DATA_W-1:0]             resp_data,
  output logic                          resp_err,
  output logic [DATA_W-1:0]             slv_out,
  output logic                          slv_out_sync,
  input  logic [DATA_W-1:0]             slv_in,
  input  logic                          slv_in_sync,
  output logic                          busy,
  output logic [GW-1:0]                 grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t                   state, state_nxt;
  logic [GW-1:0]            last_grant, last_nxt, grant_nxt;
  logic [GW-1:0]            pick_idx, cand;
  logic                     pick_found;
  logic [NUM_MASTERS-1:0]   req_ready_nxt, resp_valid_nxt;
  logic [DATA_W-1:0]        slv_out_nxt, resp_data_nxt;
  logic                     sync_nxt, err_nxt;

`ifdef MS_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // Scan upward from last_grant+1 with wrap-around; the first pending request wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_MASTERS);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_nxt       = last_grant;
    slv_out_nxt    = slv_out;
    resp_data_nxt  = resp_data;
    req_ready_nxt  = '0;
    resp_valid_nxt = '0;
    sync_nxt       = 1'b0;
    err_nxt        = 1'b0;
`ifdef MS_ARB_TIMEOUT_EN
    tmo_cnt_nxt    = (state == WAIT) ? tmo_cnt + 1'b1 : '0;
`endif
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt               = ISSUE;
          grant_nxt               = pick_idx;
          slv_out_nxt             = req_data[pick_idx*DATA_W +: DATA_W];
          req_ready_nxt[pick_idx] = 1'b1;
          sync_nxt                = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A response arriving on the timeout cycle takes priority over the error.
        if (slv_in_sync) begin
          state_nxt                = RETURN;
          resp_data_nxt            = slv_in;
          resp_valid_nxt[grant_id] = 1'b1;
        end
`ifdef MS_ARB_TIMEOUT_EN
        else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
          state_nxt                = RETURN;
          resp_data_nxt            = '0;
          resp_valid_nxt[grant_id] = 1'b1;
          err_nxt                  = 1'b1;
        end
`endif
      end
      RETURN: begin
        last_nxt  = grant_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= GW'(NUM_MASTERS - 1);
      grant_id     <= '0;
      req_ready    <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      slv_out      <= '0;
      slv_out_sync <= 1'b0;
      busy         <= 1'b0;
`ifdef MS_ARB_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      state        <= state_nxt;
      last_grant   <= last_nxt;
      grant_id     <= grant_nxt;
      req_ready    <= req_ready_nxt;
      resp_valid   <= resp_valid_nxt;
      resp_data    <= resp_data_nxt;
      resp_err     <= err_nxt;
      slv_out      <= slv_out_nxt;
      slv_out_sync <= sync_nxt;
      busy         <= (state_nxt != IDLE);
`ifdef MS_ARB_TIMEOUT_EN
      tmo_cnt      <= tmo_cnt_nxt;
`endif
    end
  end

endmodule
